// File: rtl/sliding_window_adder.sv
// sliding_window_adder
//   Streaming sum (or truncating average) of the most recent WIN = 2**LOG2_WIN
//   accepted unsigned samples. A circular sample buffer plus one running
//   accumulator give a fixed one-cycle latency regardless of window depth.
//
// Parameters
//   DW            input sample width
//   LOG2_WIN      log2 of window depth (1..8)
//   AVG           0: out_data_o = window sum, 1: out_data_o = sum >> LOG2_WIN
//   EMIT_PARTIAL  0: out_valid_o only once the window is full, 1: also while filling
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high (priority over clear_i)
//   clear_i        synchronous window flush, active-high (discards same-cycle sample)
//   in_valid_i     in_data_i accepted on this edge when high
//   in_data_i      unsigned sample
//   out_valid_o    one-cycle pulse per accepted sample that produces an output
//   out_data_o     registered window sum or average, holds between outputs
//   window_full_o  high once WIN samples accepted since last reset/clear
module sliding_window_adder #(
    parameter int unsigned DW           = 8,
    parameter int unsigned LOG2_WIN     = 4,
    parameter int unsigned AVG          = 0,
    parameter int unsigned EMIT_PARTIAL = 0,
    localparam int unsigned OW          = (AVG != 0) ? DW : DW + LOG2_WIN
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    output logic [OW-1:0] out_data_o,
    output logic          window_full_o
);

    localparam int unsigned WIN = 1 << LOG2_WIN;
    localparam int unsigned AW  = DW + LOG2_WIN;

    logic [DW-1:0]       buf_q [WIN];
    logic [LOG2_WIN-1:0] wp_q, wp_d;
    logic                full_q, full_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic                out_valid_q, out_valid_d;
    logic [OW-1:0]       out_data_q, out_data_d;

    logic          accept;
    logic [DW-1:0] oldest;
    logic [AW-1:0] acc_sum;

    assign accept = in_valid_i & ~clear_i & ~rst_i;
    assign oldest = buf_q[wp_q];

    // The oldest sample only leaves the window once the window is full; before
    // that the slot at wp_q holds stale data that was never added.
    assign acc_sum = acc_q + AW'(in_data_i) - (full_q ? AW'(oldest) : AW'(0));

    always_comb begin
        wp_d        = wp_q;
        full_d      = full_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        if (clear_i) begin
            wp_d       = '0;
            full_d     = 1'b0;
            acc_d      = '0;
            out_data_d = '0;
        end else if (in_valid_i) begin
            wp_d        = wp_q + 1'b1;
            // wp_q counts accepted samples from zero after reset/clear, so it
            // doubles as the fill count: the window fills as it wraps.
            full_d      = full_q | (wp_q == '1);
            acc_d       = acc_sum;
            out_data_d  = OW'((AVG != 0) ? (acc_sum >> LOG2_WIN) : acc_sum);
            out_valid_d = full_d | (EMIT_PARTIAL != 0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q        <= '0;
            full_q      <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wp_q        <= wp_d;
            full_q      <= full_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Sample storage is not reset; full_q gates its use after reset/clear.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            buf_q[wp_q] <= in_data_i;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign window_full_o = full_q;

endmodule

// File: tb/tb_sliding_window_adder.sv
// Bench for sliding_window_adder: three instances share one stimulus stream
//   inst 0: LOG2_WIN=2, sum,     full-window outputs only
//   inst 1: LOG2_WIN=2, average, partial outputs
//   inst 2: LOG2_WIN=4, sum,     full-window outputs only
// A history of accepted samples provides expected values; a monitor pops them.
module tb_sliding_window_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clear, in_valid;
    logic [7:0] in_data;

    logic       v0, v1, v2, f0, f1, f2;
    logic [9:0]  d0;
    logic [7:0]  d1;
    logic [11:0] d2;

    sliding_window_adder #(.DW(8), .LOG2_WIN(2), .AVG(0), .EMIT_PARTIAL(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid),
        .in_data_i(in_data), .out_valid_o(v0), .out_data_o(d0), .window_full_o(f0)
    );
    sliding_window_adder #(.DW(8), .LOG2_WIN(2), .AVG(1), .EMIT_PARTIAL(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid),
        .in_data_i(in_data), .out_valid_o(v1), .out_data_o(d1), .window_full_o(f1)
    );
    sliding_window_adder #(.DW(8), .LOG2_WIN(4), .AVG(0), .EMIT_PARTIAL(0)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid),
        .in_data_i(in_data), .out_valid_o(v2), .out_data_o(d2), .window_full_o(f2)
    );

    typedef struct {
        int          inst;
        int unsigned data;
    } exp_t;

    exp_t        expq[$];
    int unsigned hist[$];
    int unsigned exp_out[3];
    bit          exp_full[3];
    int          checks  = 0;
    int          errors  = 0;
    bit          started = 1'b0;

    function automatic int unsigned lg(int k);
        return (k == 2) ? 4 : 2;
    endfunction

    function automatic bit is_avg(int k);
        return k == 1;
    endfunction

    function automatic bit is_partial(int k);
        return k == 1;
    endfunction

    // Reference: window value = plain sum of the last min(n, WIN) accepted samples.
    task automatic model(input bit r, input bit c, input bit v, input int unsigned d);
        if (r || c) begin
            hist.delete();
            for (int k = 0; k < 3; k++) begin
                exp_out[k]  = 0;
                exp_full[k] = 1'b0;
            end
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > 16) void'(hist.pop_front());
            for (int k = 0; k < 3; k++) begin
                int unsigned win, n, m, s;
                win = 1 << lg(k);
                n   = hist.size();
                m   = (n < win) ? n : win;
                s   = 0;
                for (int i = 0; i < int'(m); i++) s += hist[n - 1 - i];
                exp_full[k] = (n >= win);
                exp_out[k]  = is_avg(k) ? (s >> lg(k)) : s;
                if (exp_full[k] || is_partial(k)) expq.push_back('{k, exp_out[k]});
            end
        end
    endtask

    task automatic step(input bit r, input bit c, input bit v, input int unsigned d);
        @(negedge clk);
        #1;
        rst      = r;
        clear    = c;
        in_valid = v;
        in_data  = d[7:0];
        @(posedge clk);
        model(r, c, v, d);
        if (r) started = 1'b1;
    endtask

    // Monitor: pop scoreboard entries for each instance that presents an output,
    // and compare held data / window_full every cycle.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                logic        v, f;
                int unsigned d;
                bit          has;
                exp_t        e;
                case (k)
                    0:       begin v = v0; f = f0; d = int'(d0); end
                    1:       begin v = v1; f = f1; d = int'(d1); end
                    default: begin v = v2; f = f2; d = int'(d2); end
                endcase
                has = (expq.size() > 0) && (expq[0].inst == k);
                if (has) begin
                    e = expq.pop_front();
                    checks++;
                    if (v !== 1'b1 || d !== e.data) begin
                        errors++;
                        $display("FAIL output inst%0d: got valid=%0b data=%0d, expected valid=1 data=%0d",
                                 k, v, d, e.data);
                    end
                end else begin
                    checks++;
                    if (v !== 1'b0) begin
                        errors++;
                        $display("FAIL spurious_valid inst%0d: got valid=%0b, expected 0", k, v);
                    end
                end
                checks++;
                if (d !== exp_out[k]) begin
                    errors++;
                    $display("FAIL out_data inst%0d: got %0d, expected %0d", k, d, exp_out[k]);
                end
                checks++;
                if (f !== exp_full[k]) begin
                    errors++;
                    $display("FAIL window_full inst%0d: got %0b, expected %0b", k, f, exp_full[k]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;

        // Reset held two cycles.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // 1..8 back-to-back.
        for (int i = 1; i <= 8; i++) step(0, 0, 1, i);

        // 1..8 with gaps carrying junk data.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, i);
            step(0, 0, 0, $urandom_range(0, 255));
        end

        // Averaging truncation.
        step(1, 0, 0, 0);
        step(0, 0, 1, 8); step(0, 0, 1, 8); step(0, 0, 1, 8); step(0, 0, 1, 9);
        step(0, 0, 1, 9); step(0, 0, 1, 9); step(0, 0, 1, 9);

        // Full-scale saturation of the 16-deep window, then drain.
        step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 1, 255);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0);

        // clear and rst mid-stream, each with a discarded sample.
        step(1, 0, 0, 0);
        step(0, 0, 1, 3); step(0, 0, 1, 5); step(0, 1, 1, 7); step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 3); step(0, 0, 1, 5); step(1, 0, 1, 7); step(0, 0, 1, 1);

        // Randomised traffic with occasional clear/reset and full-scale bursts.
        for (int i = 0; i < 600; i++) begin
            bit          r, c, v;
            int unsigned d;
            r = ($urandom_range(0, 149) == 0);
            c = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
            step(r, c, v, d);
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending outputs, expected 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
